uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver that consumes the `Txo` line produced by the team's UART transmitter.
- Recovers 8-bit frames in this format: 1 start bit, 8 data bits LSB-first, optional even-parity bit, 1 stop bit.
- Uses the same baud-select encoding and 50 MHz clock as the transmitter, so both ends share one `BC` setting.
- Presents each received byte with a one-cycle valid strobe, plus framing and parity error flags.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer on `Rxd` (minimum 2).
- DEFAULT_DIV, 434, clocks per bit used when `BC` is 0 or an unlisted code.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- Rxd  input  1  asynchronous serial line; idle high.
- BC  input  3  baud control; same encoding as the transmitter.
- PbitEna  input  1  1 = frame carries a parity bit after the data bits.
- RxData  output  8  last received byte; held until the next frame completes.
- RxValid  output  1  one-cycle strobe when `RxData` and the error flags update.
- FrameErr  output  1  stop bit sampled low on the last frame; held.
- ParityErr  output  1  parity mismatch on the last frame; held; 0 when parity is disabled.
- Busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Divisor N (clocks per bit), selected from `BC`:
  - 3'b001 → 217
  - 3'b010 → 109
  - 3'b011 → 72
  - 3'b100 → 36
  - all other codes → DEFAULT_DIV (434)
- `BC` and `PbitEna` are latched at start detection; changes mid-frame have no effect until the next frame.
- `Rxd` passes through a SYNC_STAGES flip-flop synchronizer, initialised to 1 on reset. All sampling below uses the synchronized signal `rxs`.
- Reset (synchronous): state = IDLE; `RxData`, `RxValid`, `FrameErr`, `ParityErr` and `Busy` all 0; bit counter 0; baud counter 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - Enter START on a falling edge of `rxs` (previous value 1, current value 0).
    - A line already low at reset release, or low after a framing error, does not trigger a start; a 1→0 transition is required.
  - START:
    - Count floor(N/2) cycles, then sample `rxs`.
    - Sample 0 → DATA with baud counter cleared.
    - Sample 1 → glitch; return to IDLE with no strobe.
  - DATA:
    - Every N cycles, sample `rxs` into shift-register bit [bit index], LSB first.
    - After the 8th sample, go to PARITY if latched `PbitEna` = 1, otherwise to STOP.
  - PARITY:
    - After N cycles, sample `rxs`.
    - Parity error = sample XOR (XOR of all 8 data bits); even parity overall.
  - STOP:
    - After N cycles, sample `rxs`.
    - On the cycle after this sample: load `RxData`, pulse `RxValid` for one clock, set `FrameErr` = NOT sample, set `ParityErr` (0 if parity disabled), return to IDLE.
- `RxValid` fires even on errored frames; software qualifies with the error flags.
- Latency, from the first `Rxd` low cycle to `RxValid`: SYNC_STAGES + floor(N/2) + 8N (+N if parity) + N + 1 clocks.
  - Example, BC = 0, no parity: 2 + 217 + 3472 + 434 + 1 = 4126 clocks.
- `Busy` = (state ≠ IDLE).
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit mid-point.
  - A start edge arriving half a bit later is captured; no dead time is required.
- Reset asserted mid-frame: the frame is abandoned, no strobe is produced, and the held outputs clear to 0.

Optional Feature:
- Macro: `UART_RX_BREAK_DETECT_EN`.
- Defined:
  - Adds output `Break` (1 bit, reset 0).
  - A frame whose data byte and stop sample are all 0 sets `Break` = 1 together with `RxValid` (`FrameErr` is also 1).
  - `Break` stays 1 until `rxs` has been high for one full bit period (N cycles), then clears.
  - The receiver does not re-arm until `Break` clears.
- Undefined:
  - No `Break` port.
  - A break is treated as an ordinary frame: `RxData` = 0x00, `FrameErr` = 1.

Test Plan:
- Basic receive: rst pulse, BC = 0, PbitEna = 0, drive frame 0x0B at 434 clocks/bit → one `RxValid` at 4126 clocks after start edge, `RxData` = 0x0B, `FrameErr` = 0, `ParityErr` = 0.
- Parity, good and bad: BC = 1, PbitEna = 1, frame 0x0F with parity bit 0 → `RxData` = 0x0F, `ParityErr` = 0. Same frame with parity bit 1 → `ParityErr` = 1, `RxValid` still pulses.
- Framing error and re-arm: BC = 3, frame 0x6F with stop bit held low for 2 bit times, then high → `FrameErr` = 1, `RxData` = 0x6F. A following frame 0xE8 is received cleanly with `FrameErr` = 0.
- Glitch and invalid code: BC = 7 (N = 434), 100-clock low pulse on `Rxd` → no `RxValid`, `Busy` returns to 0 after 2 + 217 clocks. Then a full frame 0x00 → `RxData` = 0x00, `FrameErr` = 0.
- Back-to-back and reset mid-frame:
  - BC = 4, frames 0x09 and 0xA5 sent with no idle gap → two `RxValid` pulses, `RxData` 0x09 then 0xA5.
  - Assert rst during DATA of a third frame → outputs clear to 0, no `RxValid`.
- Break detect (macro defined): BC = 0, `Rxd` held low for 12 bit times → `RxValid` with `RxData` = 0x00, `FrameErr` = 1, `Break` = 1. After `Rxd` is high for 434 clocks → `Break` = 0.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receiver result bus: byte, strobe, error flags and busy.
// With UART_RX_BREAK_DETECT_EN defined the bus also carries Break.
interface uart_receiver_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic       FrameErr;
  logic       ParityErr;
  logic       Busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       Break;

  modport master (output RxData, RxValid, FrameErr, ParityErr, Busy, Break);
  modport slave  (input  RxData, RxValid, FrameErr, ParityErr, Busy, Break);
`else
  modport master (output RxData, RxValid, FrameErr, ParityErr, Busy);
  modport slave  (input  RxData, RxValid, FrameErr, ParityErr, Busy);
`endif
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB-first, optional even parity, 1 stop bit.
// Optional break detection is enabled with UART_RX_BREAK_DETECT_EN.
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_DIV = 434
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rxd,
  input  logic [2:0]       BC,
  input  logic             PbitEna,
  uart_receiver_if.master  rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] flushed;
  logic                   rxs, rxs_q, fall;
  logic [15:0]            cnt, div;
  logic [2:0]             bitidx;
  logic [7:0]             shreg;
  logic                   pbit, perr, stop_s, done;

  function automatic logic [15:0] div_sel(input logic [2:0] bc);
    case (bc)
      3'b001:  div_sel = 16'd217;
      3'b010:  div_sel = 16'd109;
      3'b011:  div_sel = 16'd72;
      3'b100:  div_sel = 16'd36;
      default: div_sel = 16'(DEFAULT_DIV);
    endcase
  endfunction

  assign rxs  = sync[SYNC_STAGES-1];
  assign fall = rxs_q & ~rxs;

  // Edge history stays low until the reset ones have left the synchronizer,
  // so a line that is already low at reset release cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '1;
      flushed <= '0;
      rxs_q   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], Rxd};
      flushed <= {flushed[SYNC_STAGES-2:0], 1'b1};
      rxs_q   <= rxs & flushed[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      div          <= 16'(DEFAULT_DIV);
      bitidx       <= '0;
      shreg        <= '0;
      pbit         <= 1'b0;
      perr         <= 1'b0;
      stop_s       <= 1'b1;
      done         <= 1'b0;
      rx.RxData    <= '0;
      rx.RxValid   <= 1'b0;
      rx.FrameErr  <= 1'b0;
      rx.ParityErr <= 1'b0;
      rx.Busy      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx.Break     <= 1'b0;
`endif
    end else begin
      rx.RxValid <= 1'b0;
      done       <= 1'b0;
      // Results land one cycle after the stop sample, while already in IDLE.
      if (done) begin
        rx.RxData    <= shreg;
        rx.RxValid   <= 1'b1;
        rx.FrameErr  <= ~stop_s;
        rx.ParityErr <= perr;
`ifdef UART_RX_BREAK_DETECT_EN
        rx.Break     <= (shreg == 8'h00) && !stop_s;
`endif
      end

      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
          // Hold off re-arming until the line has been high for a full bit.
          if (rx.Break) begin
            if (rxs && cnt != div - 16'd1) cnt <= cnt + 16'd1;
            else if (rxs)                  rx.Break <= 1'b0;
          end else
`endif
          if (fall) begin
            state   <= START;
            rx.Busy <= 1'b1;
            div     <= div_sel(BC);
            pbit    <= PbitEna;
            bitidx  <= '0;
          end
        end
        START: begin
          if (cnt == {1'b0, div[15:1]} - 16'd1) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx.Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == div - 16'd1) begin
            cnt           <= '0;
            shreg[bitidx] <= rxs;
            bitidx        <= bitidx + 3'd1;
            if (bitidx == 3'd7) begin
              state <= pbit ? PARITY : STOP;
              perr  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PARITY: begin
          if (cnt == div - 16'd1) begin
            cnt   <= '0;
            perr  <= rxs ^ (^shreg);
            state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == div - 16'd1) begin
            cnt     <= '0;
            stop_s  <= rxs;
            done    <= 1'b1;
            state   <= IDLE;
            rx.Busy <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          rx.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized bench for uart_receiver; frames are checked
// against a bit-timing model computed from the frame format.
module tb_uart_receiver;
  logic       clk = 1'b0;
  logic       rst, Rxd, PbitEna;
  logic [2:0] BC;

  uart_receiver_if rxif();

  uart_receiver #(.SYNC_STAGES(2), .DEFAULT_DIV(434)) dut (
    .clk(clk), .rst(rst), .Rxd(Rxd), .BC(BC), .PbitEna(PbitEna), .rx(rxif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       fe, pe, brk;
    int         cyc;
  } ev_t;
  ev_t q[$];

  always @(negedge clk) begin
    if (rxif.RxValid === 1'b1) begin
      ev_t e;
      e.d = rxif.RxData; e.fe = rxif.FrameErr; e.pe = rxif.ParityErr; e.cyc = cyc;
`ifdef UART_RX_BREAK_DETECT_EN
      e.brk = rxif.Break;
`else
      e.brk = 1'b0;
`endif
      q.push_back(e);
    end
  end

  int nvec = 0, nmis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_clocks(input logic [2:0] bc);
    case (bc)
      3'd1:    return 217;
      3'd2:    return 109;
      3'd3:    return 72;
      3'd4:    return 36;
      default: return 434;
    endcase
  endfunction

  task automatic hold(input logic v, input int n);
    Rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; BC/PbitEna are scrambled after the start bit to show
  // they only matter at start detection.
  task automatic send(input logic [7:0] d, input logic [2:0] bc, input logic pen,
                      input logic pb, input logic stopv, input int stoplen, output int t0);
    int n;
    n = bit_clocks(bc);
    BC = bc; PbitEna = pen;
    t0 = cyc + 1;
    hold(1'b0, n);
    BC = 3'($urandom); PbitEna = 1'($urandom);
    for (int i = 0; i < 8; i++) hold(d[i], n);
    if (pen) hold(pb, n);
    hold(stopv, n * stoplen);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic [2:0] bc,
                              input logic pen, input logic pb, input logic stopv, input int t0);
    int  n, lat;
    ev_t e;
    n   = bit_clocks(bc);
    lat = 2 + n / 2 + 8 * n + (pen ? n : 0) + n + 1;
    check({tag, " valid"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, " data"},    32'(e.d),  32'(d));
      check({tag, " frameerr"}, 32'(e.fe), 32'(!stopv));
      check({tag, " parerr"},  32'(e.pe), 32'(pen ? ((^d) != pb) : 1'b0));
      check({tag, " latency"}, 32'(e.cyc - t0), 32'(lat));
    end
  endtask

  initial begin
    int t0, t1, fallc;
    logic seen;
    logic [7:0] d;
    logic [2:0] bc;
    logic pen, pb, stopv;
    logic [2:0] fast[3] = '{3'd2, 3'd3, 3'd4};

    // Reset with the line low; release must not start a frame.
    rst = 1'b1; Rxd = 1'b0; BC = 3'd4; PbitEna = 1'b0;
    repeat (4) @(negedge clk);
    check("rst RxData",    32'(rxif.RxData),    32'd0);
    check("rst RxValid",   32'(rxif.RxValid),   32'd0);
    check("rst FrameErr",  32'(rxif.FrameErr),  32'd0);
    check("rst ParityErr", 32'(rxif.ParityErr), 32'd0);
    check("rst Busy",      32'(rxif.Busy),      32'd0);
    rst = 1'b0; seen = 1'b0;
    repeat (300) begin @(negedge clk); if (rxif.Busy) seen = 1'b1; end
    check("low at release busy", 32'(seen), 32'd0);
    check("low at release strobe", 32'(q.size()), 32'd0);
    hold(1'b1, 50);

    send(8'h0B, 3'd0, 1'b0, 1'b0, 1'b1, 1, t0); hold(1'b1, 50);
    expect_frame("basic", 8'h0B, 3'd0, 1'b0, 1'b0, 1'b1, t0);

    send(8'h0F, 3'd1, 1'b1, 1'b0, 1'b1, 1, t0); hold(1'b1, 217);
    expect_frame("parity good", 8'h0F, 3'd1, 1'b1, 1'b0, 1'b1, t0);
    send(8'h0F, 3'd1, 1'b1, 1'b1, 1'b1, 1, t0); hold(1'b1, 217);
    expect_frame("parity bad", 8'h0F, 3'd1, 1'b1, 1'b1, 1'b1, t0);

    send(8'h6F, 3'd3, 1'b0, 1'b0, 1'b0, 2, t0); hold(1'b1, 72);
    expect_frame("framing", 8'h6F, 3'd3, 1'b0, 1'b0, 1'b0, t0);
    send(8'hE8, 3'd3, 1'b0, 1'b0, 1'b1, 1, t0); hold(1'b1, 72);
    expect_frame("rearm", 8'hE8, 3'd3, 1'b0, 1'b0, 1'b1, t0);

    // Short low pulse with an unlisted code: a glitch rejected at mid start bit.
    BC = 3'd7; PbitEna = 1'b0; seen = 1'b0; fallc = -1;
    t0 = cyc + 1; Rxd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 100) Rxd = 1'b1;
      @(negedge clk);
      if (rxif.Busy) seen = 1'b1;
      else if (seen && fallc < 0) fallc = cyc;
    end
    check("glitch busy seen", 32'(seen), 32'd1);
    check("glitch busy drop", 32'(fallc - t0), 32'(2 + 434 / 2));
    check("glitch strobe", 32'(q.size()), 32'd0);
    send(8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1, t0); hold(1'b1, 100);
    expect_frame("zero byte", 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, t0);

    send(8'h09, 3'd4, 1'b0, 1'b0, 1'b1, 1, t0);
    send(8'hA5, 3'd4, 1'b0, 1'b0, 1'b1, 1, t1);
    hold(1'b1, 36);
    expect_frame("b2b first", 8'h09, 3'd4, 1'b0, 1'b0, 1'b1, t0);
    expect_frame("b2b second", 8'hA5, 3'd4, 1'b0, 1'b0, 1'b1, t1);

    // Third frame abandoned by reset during its data bits.
    BC = 3'd4;
    hold(1'b0, 36); hold(1'b1, 36); hold(1'b0, 36); hold(1'b1, 20);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst RxData",    32'(rxif.RxData),    32'd0);
    check("midrst FrameErr",  32'(rxif.FrameErr),  32'd0);
    check("midrst ParityErr", 32'(rxif.ParityErr), 32'd0);
    check("midrst Busy",      32'(rxif.Busy),      32'd0);
    rst = 1'b0;
    hold(1'b1, 36 * 12);
    check("midrst strobe", 32'(q.size()), 32'd0);
    check("midrst RxData after", 32'(rxif.RxData), 32'd0);

    for (int k = 0; k < 12; k++) begin
      d     = 8'($urandom);
      bc    = fast[$urandom_range(0, 2)];
      pen   = 1'($urandom_range(0, 1));
      pb    = (^d) ^ ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 4) != 0);
      if (!stopv && d == 8'h00) d = 8'h5A;
      send(d, bc, pen, pb, stopv, 1, t0);
      hold(1'b1, bit_clocks(bc));
      expect_frame($sformatf("rand%0d", k), d, bc, pen, pb, stopv, t0);
    end

`ifdef UART_RX_BREAK_DETECT_EN
    begin
      ev_t e;
      BC = 3'd0; PbitEna = 1'b0;
      hold(1'b0, 12 * 434);
      check("break valid", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("break data", 32'(e.d),   32'd0);
        check("break fe",   32'(e.fe),  32'd1);
        check("break flag", 32'(e.brk), 32'd1);
      end
      hold(1'b1, 300);
      check("break held", 32'(rxif.Break), 32'd1);
      hold(1'b1, 140);
      check("break clear", 32'(rxif.Break), 32'd0);
    end
`endif

    check("no stray strobes", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
